// File: rtl/wrr_arb_tree.sv
// Weighted round-robin arbiter: NumIn requesters feed one valid/ready port.
// Each input may take up to weight consecutive grants before ownership rotates.
// A weight of 0 counts as 1.
// Optional build macro WRR_ARB_OUT_REG_EN adds a registered output slice with
// full throughput. Decision lock-in is then unused, because the slice holds
// the payload itself.
module wrr_arb_tree #(
    parameter int NumIn       = 8,
    parameter int DataWidth   = 32,
    parameter int WeightWidth = 4,
    parameter int LockIn      = 1,
    parameter int IdxWidth    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NumIn-1:0]             req_i,
    output logic [NumIn-1:0]             gnt_o,
    input  logic [NumIn*DataWidth-1:0]   data_i,
    input  logic [NumIn*WeightWidth-1:0] weight_i,
    output logic                         req_o,
    input  logic                         gnt_i,
    output logic [DataWidth-1:0]         data_o,
    output logic [IdxWidth-1:0]          idx_o
);

    // Arbiter-side result, before the optional output slice
    logic                 w_arb_req;
    logic [IdxWidth-1:0]  w_sel;
    logic [DataWidth-1:0] w_arb_data;
    logic                 w_accept;
    logic                 w_hs;

    logic [DataWidth-1:0]   w_data_arr   [NumIn];
    logic [WeightWidth-1:0] w_weight_arr [NumIn];

    // Unpack the flat payload and weight buses into per-input lanes
    for (genvar gi = 0; gi < NumIn; gi++) begin : g_unpack
        assign w_data_arr[gi]   = data_i[gi*DataWidth +: DataWidth];
        assign w_weight_arr[gi] = weight_i[gi*WeightWidth +: WeightWidth];
    end

`ifdef WRR_ARB_OUT_REG_EN
    localparam int UseLock = 0;

    logic                 r_vld;
    logic [DataWidth-1:0] r_data;
    logic [IdxWidth-1:0]  r_idx;

    // Slice takes a new beat whenever it is empty or its beat leaves this cycle
    assign w_accept = !r_vld || gnt_i;

    // Output slice register: refills on accept, cleared by reset or flush
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_vld  <= w_arb_req;
            r_data <= w_arb_data;
            r_idx  <= w_sel;
        end
    end

    assign req_o  = !rst_i && r_vld;
    assign data_o = rst_i ? '0 : r_data;
    assign idx_o  = rst_i ? '0 : r_idx;
`else
    localparam int UseLock = LockIn;

    assign w_accept = gnt_i;
    assign req_o    = !rst_i && w_arb_req;
    assign data_o   = rst_i ? '0 : w_arb_data;
    assign idx_o    = rst_i ? '0 : w_sel;
`endif

    // A beat leaves the arbiter: the winner is granted in this same cycle
    assign w_hs = !rst_i && w_arb_req && w_accept;

    // Per-input grant: only the current winner, only on a completed handshake
    for (genvar gi = 0; gi < NumIn; gi++) begin : g_gnt
        assign gnt_o[gi] = w_hs && (w_sel == IdxWidth'(gi));
    end

    if (NumIn == 1) begin : g_single
        // Single requester: straight pass-through, nothing to remember
        assign w_arb_req  = req_i[0];
        assign w_sel      = '0;
        assign w_arb_data = req_i[0] ? w_data_arr[0] : '0;
    end else begin : g_core
        logic [IdxWidth-1:0]    r_rr;
        logic [WeightWidth-1:0] r_cnt;
        logic                   r_lock;
        logic [IdxWidth-1:0]    r_lockidx;

        logic [IdxWidth-1:0]    w_search;
        logic                   w_found;
        logic [IdxWidth:0]      w_cand;
        logic [WeightWidth:0]   w_wt;
        logic [WeightWidth:0]   w_cplus;
        logic [IdxWidth-1:0]    w_rr_next;
        logic [WeightWidth-1:0] w_cnt_next;

        // Circular first-requester search starting at the owner pointer
        always_comb begin
            w_search = '0;
            w_found  = 1'b0;
            w_cand   = '0;
            for (int k = 0; k < NumIn; k++) begin
                w_cand = {1'b0, r_rr} + (IdxWidth+1)'(k);
                if (w_cand >= (IdxWidth+1)'(NumIn)) begin
                    w_cand = w_cand - (IdxWidth+1)'(NumIn);
                end
                if (!w_found && req_i[w_cand[IdxWidth-1:0]]) begin
                    w_found  = 1'b1;
                    w_search = w_cand[IdxWidth-1:0];
                end
            end
        end

        assign w_arb_req  = r_lock || (|req_i);
        assign w_sel      = r_lock ? r_lockidx : (w_found ? w_search : '0);
        assign w_arb_data = w_arb_req ? w_data_arr[w_sel] : '0;

        // Burst accounting: credit only carries over when the owner wins again
        always_comb begin
            w_wt = {1'b0, w_weight_arr[w_sel]};
            if (w_wt == '0) begin
                w_wt = (WeightWidth+1)'(1);
            end
            w_cplus    = (w_sel == r_rr) ? ({1'b0, r_cnt} + (WeightWidth+1)'(1))
                                         : (WeightWidth+1)'(1);
            w_rr_next  = r_rr;
            w_cnt_next = r_cnt;
            if (w_hs) begin
                if (w_cplus >= w_wt) begin
                    w_rr_next  = (w_sel == IdxWidth'(NumIn-1)) ? '0
                                                               : w_sel + IdxWidth'(1);
                    w_cnt_next = '0;
                end else begin
                    w_rr_next  = w_sel;
                    w_cnt_next = w_cplus[WeightWidth] ? '1 : w_cplus[WeightWidth-1:0];
                end
            end
        end

        // Arbiter state: owner pointer, burst count and held decision
        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                r_rr      <= '0;
                r_cnt     <= '0;
                r_lock    <= 1'b0;
                r_lockidx <= '0;
            end else begin
                r_rr      <= w_rr_next;
                r_cnt     <= w_cnt_next;
                r_lock    <= (UseLock != 0) && w_arb_req && !gnt_i;
                r_lockidx <= w_sel;
            end
        end

        // A held decision is only valid while its requester keeps asking
        a_lock_req_held: assert property (
            @(posedge clk_i) disable iff (rst_i) r_lock |-> req_i[r_lockidx]
        );
    end

endmodule

// File: tb/tb_wrr_arb_tree.sv
// Scoreboard bench for wrr_arb_tree (NumIn=4, combinational output build).
// The driver applies one directed vector per cycle and queues the expected
// outputs; a monitor on the falling edge pops and compares them.
module tb_wrr_arb_tree;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic [N-1:0]    req_i = '0;
    logic [N-1:0]    gnt_o;
    logic [N*DW-1:0] data_i;
    logic [N*WW-1:0] weight_i = '0;
    logic            req_o;
    logic            gnt_i = 1'b0;
    logic [DW-1:0]   data_o;
    logic [1:0]      idx_o;

    typedef struct {
        logic          req;
        logic [1:0]    idx;
        logic [DW-1:0] data;
        logic [N-1:0]  gnt;
        string         name;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] dtab [N];
    logic [N*WW-1:0] w_cfg = 16'h1111;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    wrr_arb_tree #(
        .NumIn(N), .DataWidth(DW), .WeightWidth(WW), .LockIn(1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .req_i(req_i), .gnt_o(gnt_o), .data_i(data_i), .weight_i(weight_i),
        .req_o(req_o), .gnt_i(gnt_i), .data_o(data_o), .idx_o(idx_o)
    );

    // One cycle of stimulus plus its expected outputs
    task automatic step(input logic [N-1:0] req, input logic g, input logic fl,
                        input logic rs, input logic er, input int ei, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        req_i    = req;
        gnt_i    = g;
        flush_i  = fl;
        rst_i    = rs;
        weight_i = w_cfg;
        e.req  = er;
        e.idx  = 2'(ei);
        e.data = er ? dtab[ei] : '0;
        e.gnt  = (er && g) ? N'(1 << ei) : '0;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (req_o !== e.req || idx_o !== e.idx || data_o !== e.data || gnt_o !== e.gnt) begin
                    n_errors++;
                    $display("FAIL %s: got req=%0b idx=%0d data=%h gnt=%b, expected req=%0b idx=%0d data=%h gnt=%b",
                             e.name, req_o, idx_o, data_o, gnt_o, e.req, e.idx, e.data, e.gnt);
                end else begin
                    $display("ok   %s: req=%0b idx=%0d data=%h gnt=%b", e.name, req_o, idx_o, data_o, gnt_o);
                end
            end else if (req_o && gnt_i) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_hs: got idx=%0d gnt=%b, expected no transfer", idx_o, gnt_o);
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int seq_w [12] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2};
        dtab[0] = 16'h1A11;
        dtab[1] = 16'h2B22;
        dtab[2] = 16'h3C33;
        dtab[3] = 16'h4D44;
        data_i  = {dtab[3], dtab[2], dtab[1], dtab[0]};

        // Reset forces outputs low even with every input requesting
        repeat (2) step(4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 0, "rst_hold");

        // Equal weights: plain rotation
        w_cfg = 16'h1111;
        for (int k = 0; k < 8; k++) step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, k % 4, "rr_equal");

        // Weights w0=3 w1=1 w2=2 w3=1, ending mid-burst at owner 2 with one grant
        w_cfg = 16'h1213;
        for (int k = 0; k < 12; k++) step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, seq_w[k], "wrr_burst");

        // Flush together with a handshake: grant completes, state clears
        step(4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 2, "flush_hs");
        step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 0, "post_flush");
        step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 0, "wrr_burst");
        step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 0, "wrr_burst");
        step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 1, "wrr_burst");
        step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 2, "wrr_burst");

        // Reset mid-burst at owner 2
        repeat (2) step(4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 0, "rst_mid");
        step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 0, "post_rst");

        // No requests: idle outputs, no grant even with downstream ready
        step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, "idle");

        // Lock-in: stall on input 1, input 0 arrives during the stall
        w_cfg = 16'h1111;
        repeat (3) step(4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1, "lock_stall");
        step(4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1, "lock_hold");
        step(4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 1, "lock_release");
        step(4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 2, "after_lock");
        step(4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 0, "after_lock");

        // Owner 0 (weight 4) drops after 2 grants; its credit is lost
        w_cfg = 16'h1114;
        step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 0, "flush_idle");
        repeat (2) step(4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 0, "owner_burst");
        step(4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 3, "owner_drop");
        repeat (4) step(4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 0, "fresh_burst");
        step(4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 3, "fresh_rotate");

        // Weight 0 behaves as weight 1
        w_cfg = 16'h0000;
        for (int k = 0; k < 4; k++) step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, k, "weight_zero");

        // Maximum weight 15 on input 0: fifteen grants, then rotation
        w_cfg = 16'h000F;
        for (int k = 0; k < 15; k++) step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 0, "weight_max");
        step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 1, "weight_max_rot");

        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, "final_idle");
        repeat (3) @(posedge clk);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
